// File: rtl/gpio_axil_responder.sv
// ============================================================================
// Module   : gpio_axil_responder
// Brief    : AXI4-Lite slave exposing a 32-bit GPIO block (OUT, IN, DIR).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpio_axil_responder #(
    parameter logic [63:0] BaseAddr = 64'h0010_0000,
    parameter logic [63:0] Length   = 64'h0001_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [63:0] aw_addr_i,
    input  logic        aw_valid_i,
    output logic        aw_ready_o,
    input  logic [31:0] w_data_i,
    input  logic [3:0]  w_strb_i,
    input  logic        w_valid_i,
    output logic        w_ready_o,
    output logic [1:0]  b_resp_o,
    output logic        b_valid_o,
    input  logic        b_ready_i,
    input  logic [63:0] ar_addr_i,
    input  logic        ar_valid_i,
    output logic        ar_ready_o,
    output logic [31:0] r_data_o,
    output logic [1:0]  r_resp_o,
    output logic        r_valid_o,
    input  logic        r_ready_i,
    input  logic [31:0] gpio_i,
    output logic [31:0] gpio_o,
    output logic [31:0] gpio_oe_o
);

    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_RESP = 1'b1;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    localparam logic [1:0] c_RESP_OKAY   = 2'b00;
    localparam logic [1:0] c_RESP_SLVERR = 2'b10;
    localparam logic [1:0] c_RESP_DECERR = 2'b11;

    logic [0:0]  r_wstate;
    logic [0:0]  r_rstate;
    logic [1:0]  r_bresp;
    logic [1:0]  r_rresp;
    logic [31:0] r_rdata;
    logic [31:0] r_out;
    logic [31:0] r_dir;
    logic [31:0] r_sync1;
    logic [31:0] r_sync2;

    logic [63:0] w_aw_off;
    logic [63:0] w_ar_off;
    logic        w_aw_in;
    logic        w_aw_map;
    logic        w_ar_in;
    logic        w_ar_map;
    logic [1:0]  w_aw_resp;
    logic [1:0]  w_ar_resp;
    logic        w_wr_hs;
    logic        w_rd_hs;
    logic [31:0] w_out_nxt;
    logic [31:0] w_dir_nxt;
    logic [31:0] w_rd_data;
    logic        w_unused;

    // Subtraction is only trusted once addr >= base, so no wrap can fake a hit.
    assign w_aw_off = aw_addr_i - BaseAddr;
    assign w_ar_off = ar_addr_i - BaseAddr;
    assign w_aw_in  = (aw_addr_i >= BaseAddr) && (w_aw_off < Length);
    assign w_ar_in  = (ar_addr_i >= BaseAddr) && (w_ar_off < Length);
    assign w_aw_map = w_aw_in && (w_aw_off[63:4] == 60'd0) && (w_aw_off[3:2] != 2'd3);
    assign w_ar_map = w_ar_in && (w_ar_off[63:4] == 60'd0) && (w_ar_off[3:2] != 2'd3);

    assign w_aw_resp = !w_aw_in ? c_RESP_DECERR : (!w_aw_map ? c_RESP_SLVERR : c_RESP_OKAY);
    assign w_ar_resp = !w_ar_in ? c_RESP_DECERR : (!w_ar_map ? c_RESP_SLVERR : c_RESP_OKAY);

    assign w_unused = &{1'b0, w_aw_off[1:0], w_ar_off[1:0]};

    // AW and W are only ever accepted together.
    assign w_wr_hs    = (r_wstate == W_IDLE) && aw_valid_i && w_valid_i && !rst_i;
    assign aw_ready_o = w_wr_hs;
    assign w_ready_o  = w_wr_hs;
    assign ar_ready_o = (r_rstate == R_IDLE) && !rst_i;
    assign w_rd_hs    = ar_ready_o && ar_valid_i;

    always_comb begin
        w_out_nxt = r_out;
        w_dir_nxt = r_dir;
        if (w_wr_hs && w_aw_map) begin
            for (int i = 0; i < 4; i++) begin
                if (w_strb_i[i]) begin
                    if (w_aw_off[3:2] == 2'd0) w_out_nxt[8*i +: 8] = w_data_i[8*i +: 8];
                    if (w_aw_off[3:2] == 2'd2) w_dir_nxt[8*i +: 8] = w_data_i[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        w_rd_data = 32'd0;
        if (w_ar_map) begin
            case (w_ar_off[3:2])
                2'd0:    w_rd_data = r_out;
                2'd1:    w_rd_data = r_sync2;
                2'd2:    w_rd_data = r_dir;
                default: w_rd_data = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync1  <= 32'd0;
            r_sync2  <= 32'd0;
            r_out    <= 32'd0;
            r_dir    <= 32'd0;
            r_wstate <= W_IDLE;
            r_bresp  <= 2'b00;
            r_rstate <= R_IDLE;
            r_rresp  <= 2'b00;
            r_rdata  <= 32'd0;
        end else begin
            r_sync1 <= gpio_i;
            r_sync2 <= r_sync1;
            r_out   <= w_out_nxt;
            r_dir   <= w_dir_nxt;

            case (r_wstate)
                W_IDLE: begin
                    if (w_wr_hs) begin
                        r_bresp  <= w_aw_resp;
                        r_wstate <= W_RESP;
                    end
                end
                default: begin
                    if (b_ready_i) r_wstate <= W_IDLE;
                end
            endcase

            // Read data is sampled before this edge's register write lands.
            case (r_rstate)
                R_IDLE: begin
                    if (w_rd_hs) begin
                        r_rdata  <= w_rd_data;
                        r_rresp  <= w_ar_resp;
                        r_rstate <= R_DATA;
                    end
                end
                default: begin
                    if (r_ready_i) r_rstate <= R_IDLE;
                end
            endcase
        end
    end

    assign b_valid_o = (r_wstate == W_RESP);
    assign b_resp_o  = r_bresp;
    assign r_valid_o = (r_rstate == R_DATA);
    assign r_resp_o  = r_rresp;
    assign r_data_o  = r_rdata;
    assign gpio_o    = r_out;
    assign gpio_oe_o = r_dir;

endmodule

`default_nettype wire

// File: tb/tb_gpio_axil_responder.sv
// ============================================================================
// Module   : tb_gpio_axil_responder
// Brief    : Vector-table and scoreboard bench for gpio_axil_responder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gpio_axil_responder;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [63:0] aw_addr_i;
    logic        aw_valid_i;
    logic        aw_ready_o;
    logic [31:0] w_data_i;
    logic [3:0]  w_strb_i;
    logic        w_valid_i;
    logic        w_ready_o;
    logic [1:0]  b_resp_o;
    logic        b_valid_o;
    logic        b_ready_i;
    logic [63:0] ar_addr_i;
    logic        ar_valid_i;
    logic        ar_ready_o;
    logic [31:0] r_data_o;
    logic [1:0]  r_resp_o;
    logic        r_valid_o;
    logic        r_ready_i;
    logic [31:0] gpio_i;
    logic [31:0] gpio_o;
    logic [31:0] gpio_oe_o;

    gpio_axil_responder dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .aw_addr_i  (aw_addr_i),
        .aw_valid_i (aw_valid_i),
        .aw_ready_o (aw_ready_o),
        .w_data_i   (w_data_i),
        .w_strb_i   (w_strb_i),
        .w_valid_i  (w_valid_i),
        .w_ready_o  (w_ready_o),
        .b_resp_o   (b_resp_o),
        .b_valid_o  (b_valid_o),
        .b_ready_i  (b_ready_i),
        .ar_addr_i  (ar_addr_i),
        .ar_valid_i (ar_valid_i),
        .ar_ready_o (ar_ready_o),
        .r_data_o   (r_data_o),
        .r_resp_o   (r_resp_o),
        .r_valid_o  (r_valid_o),
        .r_ready_i  (r_ready_i),
        .gpio_i     (gpio_i),
        .gpio_o     (gpio_o),
        .gpio_oe_o  (gpio_oe_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        wr;
        logic [63:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic [31:0] gout;
        logic [31:0] goe;
    } vec_t;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
    } exp_t;

    exp_t wq[$];
    exp_t rq[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic idle_inputs();
        aw_valid_i = 1'b0;
        w_valid_i  = 1'b0;
        ar_valid_i = 1'b0;
        b_ready_i  = 1'b1;
        r_ready_i  = 1'b1;
    endtask

    // Called just after a rising edge; returns just after a rising edge.
    task automatic do_write(input logic [63:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic [1:0] er);
        int   n;
        exp_t e;
        aw_addr_i = a; w_data_i = d; w_strb_i = s;
        aw_valid_i = 1'b1; w_valid_i = 1'b1; b_ready_i = 1'b1;
        @(negedge clk_i);
        n = 0;
        while (!aw_ready_o && n < 20) begin @(negedge clk_i); n++; end
        chk("wr_accept", {63'd0, aw_ready_o}, 64'd1);
        e.resp = er; e.data = 32'd0;
        wq.push_back(e);
        @(posedge clk_i); #1;
        aw_valid_i = 1'b0; w_valid_i = 1'b0;
        @(negedge clk_i);
        chk("b_valid", {63'd0, b_valid_o}, 64'd1);
        if (b_valid_o && wq.size() > 0) begin
            e = wq.pop_front();
            chk("b_resp", {62'd0, b_resp_o}, {62'd0, e.resp});
        end
        @(posedge clk_i); #1;
    endtask

    task automatic do_read(input logic [63:0] a, input logic [1:0] er, input logic [31:0] ed);
        int   n;
        exp_t e;
        ar_addr_i = a; ar_valid_i = 1'b1; r_ready_i = 1'b1;
        @(negedge clk_i);
        n = 0;
        while (!ar_ready_o && n < 20) begin @(negedge clk_i); n++; end
        chk("ar_accept", {63'd0, ar_ready_o}, 64'd1);
        e.resp = er; e.data = ed;
        rq.push_back(e);
        @(posedge clk_i); #1;
        ar_valid_i = 1'b0;
        @(negedge clk_i);
        chk("r_valid", {63'd0, r_valid_o}, 64'd1);
        if (r_valid_o && rq.size() > 0) begin
            e = rq.pop_front();
            chk("r_resp", {62'd0, r_resp_o}, {62'd0, e.resp});
            chk("r_data", {32'd0, r_data_o}, {32'd0, e.data});
        end
        @(posedge clk_i); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[16];
        exp_t e;
        logic [1:0] held_resp;

        vecs[0]  = '{1'b1, 64'h0010_0000, 32'hA5A5_0F0F, 4'hF, 2'b00, 32'h0, 32'hA5A5_0F0F, 32'h0000_0000};
        vecs[1]  = '{1'b1, 64'h0010_0008, 32'h0000_FFFF, 4'h1, 2'b00, 32'h0, 32'hA5A5_0F0F, 32'h0000_00FF};
        vecs[2]  = '{1'b0, 64'h0010_0000, 32'h0,         4'h0, 2'b00, 32'hA5A5_0F0F, 32'h0, 32'h0};
        vecs[3]  = '{1'b0, 64'h0010_0008, 32'h0,         4'h0, 2'b00, 32'h0000_00FF, 32'h0, 32'h0};
        vecs[4]  = '{1'b1, 64'h0010_000C, 32'h1234_5678, 4'hF, 2'b10, 32'h0, 32'hA5A5_0F0F, 32'h0000_00FF};
        vecs[5]  = '{1'b0, 64'h8000_0000, 32'h0,         4'h0, 2'b11, 32'h0, 32'h0, 32'h0};
        vecs[6]  = '{1'b0, 64'h0010_000C, 32'h0,         4'h0, 2'b10, 32'h0, 32'h0, 32'h0};
        vecs[7]  = '{1'b1, 64'h0010_0004, 32'hFFFF_FFFF, 4'hF, 2'b00, 32'h0, 32'hA5A5_0F0F, 32'h0000_00FF};
        vecs[8]  = '{1'b1, 64'h0010_0000, 32'h0000_0000, 4'h0, 2'b00, 32'h0, 32'hA5A5_0F0F, 32'h0000_00FF};
        vecs[9]  = '{1'b1, 64'h0010_0000, 32'h1122_3344, 4'hA, 2'b00, 32'h0, 32'h11A5_330F, 32'h0000_00FF};
        vecs[10] = '{1'b1, 64'h0011_0000, 32'hFFFF_FFFF, 4'hF, 2'b11, 32'h0, 32'h11A5_330F, 32'h0000_00FF};
        vecs[11] = '{1'b0, 64'h000F_FFFC, 32'h0,         4'h0, 2'b11, 32'h0, 32'h0, 32'h0};
        vecs[12] = '{1'b1, 64'h0010_0010, 32'hFFFF_FFFF, 4'hF, 2'b10, 32'h0, 32'h11A5_330F, 32'h0000_00FF};
        vecs[13] = '{1'b0, 64'h0010_0004, 32'h0,         4'h0, 2'b00, 32'h1234_5678, 32'h0, 32'h0};
        vecs[14] = '{1'b0, 64'h0010_FFFC, 32'h0,         4'h0, 2'b10, 32'h0, 32'h0, 32'h0};
        vecs[15] = '{1'b1, 64'h0010_0008, 32'hFFFF_0000, 4'hC, 2'b00, 32'h0, 32'h11A5_330F, 32'hFFFF_00FF};

        // Reset with every request asserted: nothing may be accepted.
        rst_i = 1'b1;
        gpio_i = 32'h1234_5678;
        aw_addr_i = 64'h0010_0000; w_data_i = 32'hFFFF_FFFF; w_strb_i = 4'hF;
        ar_addr_i = 64'h0010_0000;
        aw_valid_i = 1'b1; w_valid_i = 1'b1; ar_valid_i = 1'b1;
        b_ready_i = 1'b1; r_ready_i = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_aw_ready", {63'd0, aw_ready_o}, 64'd0);
        chk("rst_w_ready",  {63'd0, w_ready_o},  64'd0);
        chk("rst_ar_ready", {63'd0, ar_ready_o}, 64'd0);
        chk("rst_b_valid",  {63'd0, b_valid_o},  64'd0);
        chk("rst_r_valid",  {63'd0, r_valid_o},  64'd0);
        chk("rst_gpio_o",   {32'd0, gpio_o},     64'd0);
        chk("rst_gpio_oe",  {32'd0, gpio_oe_o},  64'd0);
        chk("rst_r_data",   {32'd0, r_data_o},   64'd0);
        chk("rst_resps",    {60'd0, b_resp_o, r_resp_o}, 64'd0);
        idle_inputs();
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #1;

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].resp);
                chk("vec_gpio_o",  {32'd0, gpio_o},    {32'd0, vecs[i].gout});
                chk("vec_gpio_oe", {32'd0, gpio_oe_o}, {32'd0, vecs[i].goe});
            end else begin
                do_read(vecs[i].addr, vecs[i].resp, vecs[i].rdata);
            end
        end

        // AW alone waits for W; B held without ready while AR is still served.
        aw_addr_i = 64'h0010_0000; aw_valid_i = 1'b1; w_valid_i = 1'b0; b_ready_i = 1'b0;
        ar_addr_i = 64'h0010_0008; ar_valid_i = 1'b1; r_ready_i = 1'b1;
        e.resp = 2'b00; e.data = 32'hFFFF_00FF;
        rq.push_back(e);
        @(negedge clk_i);
        chk("aw_alone_ready", {63'd0, aw_ready_o}, 64'd0);
        chk("ar_concurrent",  {63'd0, ar_ready_o}, 64'd1);
        @(posedge clk_i); #1;
        ar_valid_i = 1'b0;
        @(negedge clk_i);
        chk("aw_alone_ready2", {63'd0, aw_ready_o}, 64'd0);
        chk("r_valid_conc",    {63'd0, r_valid_o},  64'd1);
        e = rq.pop_front();
        chk("r_data_conc", {32'd0, r_data_o}, {32'd0, e.data});
        chk("r_resp_conc", {62'd0, r_resp_o}, {62'd0, e.resp});
        @(posedge clk_i); #1;
        w_data_i = 32'hDEAD_BEEF; w_strb_i = 4'hF; w_valid_i = 1'b1;
        e.resp = 2'b00; e.data = 32'h0;
        wq.push_back(e);
        @(negedge clk_i);
        chk("wr_pair_ready", {62'd0, aw_ready_o, w_ready_o}, 64'd3);
        @(posedge clk_i); #1;
        e = wq.pop_front();
        held_resp = e.resp;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            chk("b_hold_valid", {63'd0, b_valid_o}, 64'd1);
            chk("b_hold_resp",  {62'd0, b_resp_o},  {62'd0, held_resp});
            chk("b_hold_noacc", {63'd0, aw_ready_o}, 64'd0);
            @(posedge clk_i); #1;
        end
        chk("gpio_o_deadbeef", {32'd0, gpio_o}, 64'h0000_0000_DEAD_BEEF);
        aw_valid_i = 1'b0; w_valid_i = 1'b0; b_ready_i = 1'b1;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("b_release", {63'd0, b_valid_o}, 64'd0);
        @(posedge clk_i); #1;

        // Same-cycle write and read of OUT: read returns the pre-write value.
        aw_addr_i = 64'h0010_0000; w_data_i = 32'h0; w_strb_i = 4'hF;
        ar_addr_i = 64'h0010_0000;
        aw_valid_i = 1'b1; w_valid_i = 1'b1; ar_valid_i = 1'b1;
        @(negedge clk_i);
        chk("same_cycle_ready", {62'd0, aw_ready_o, ar_ready_o}, 64'd3);
        @(posedge clk_i); #1;
        idle_inputs();
        @(negedge clk_i);
        chk("same_cycle_rdata", {32'd0, r_data_o}, 64'h0000_0000_DEAD_BEEF);
        chk("same_cycle_gpio",  {32'd0, gpio_o},   64'd0);
        @(posedge clk_i); #1;

        // R held without ready while pins change; then IN follows after sync.
        ar_addr_i = 64'h0010_0004; ar_valid_i = 1'b1; r_ready_i = 1'b0;
        @(posedge clk_i); #1;
        ar_valid_i = 1'b0;
        gpio_i = 32'hCAFE_F00D;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("r_hold_data", {32'd0, r_data_o}, 64'h0000_0000_1234_5678);
            chk("r_hold_valid", {63'd0, r_valid_o}, 64'd1);
            @(posedge clk_i); #1;
        end
        r_ready_i = 1'b1;
        @(posedge clk_i); #1;
        do_read(64'h0010_0004, 2'b00, 32'hCAFE_F00D);

        // Reset while both responses are pending drops them.
        aw_addr_i = 64'h0010_0000; w_data_i = 32'h5555_AAAA; w_strb_i = 4'hF;
        ar_addr_i = 64'h0010_0000;
        aw_valid_i = 1'b1; w_valid_i = 1'b1; ar_valid_i = 1'b1;
        b_ready_i = 1'b0; r_ready_i = 1'b0;
        @(posedge clk_i); #1;
        aw_valid_i = 1'b0; w_valid_i = 1'b0; ar_valid_i = 1'b0;
        @(negedge clk_i);
        chk("pre_rst_valids", {62'd0, b_valid_o, r_valid_o}, 64'd3);
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        chk("mid_rst_valids", {62'd0, b_valid_o, r_valid_o}, 64'd0);
        chk("mid_rst_gpio",   {gpio_o, gpio_oe_o}, 64'd0);
        chk("mid_rst_rdata",  {32'd0, r_data_o}, 64'd0);
        rst_i = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk_i);
        #1;
        do_read(64'h0010_0008, 2'b00, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/gpio_axil_responder.md
GPIO_AXIL_RESPONDER -- requirements
Module: gpio_axil_responder

Interface
REQ-001 SHALL have parameter BaseAddr, default 64'h0010_0000, GPIO window base.
REQ-002 SHALL have parameter Length, default 64'h10000, GPIO window size in bytes.
REQ-003 SHALL have port clk_i, input, 1 bit: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have ports aw_addr_i in 64, aw_valid_i in 1, aw_ready_o out 1: write address channel.
REQ-006 SHALL have ports w_data_i in 32, w_strb_i in 4, w_valid_i in 1, w_ready_o out 1: write data channel.
REQ-007 SHALL have ports b_resp_o out 2, b_valid_o out 1, b_ready_i in 1: write response channel.
REQ-008 SHALL have ports ar_addr_i in 64, ar_valid_i in 1, ar_ready_o out 1: read address channel.
REQ-009 SHALL have ports r_data_o out 32, r_resp_o out 2, r_valid_o out 1, r_ready_i in 1: read data channel.
REQ-010 SHALL have port gpio_i, input, 32: asynchronous pin inputs.
REQ-011 SHALL have ports gpio_o, output, 32, and gpio_oe_o, output, 32: pin drive value and per-pin output enable.

Function
REQ-012 SHALL decode offset = addr - BaseAddr; hit when BaseAddr <= addr < BaseAddr+Length, 64-bit unsigned compare, no overflow wrap.
REQ-013 SHALL implement registers at offset[3:2], offset[15:4]=0: 0 OUT (RW, drives gpio_o), 1 IN (RO), 2 DIR (RW, drives gpio_oe_o).
REQ-014 SHALL synchronise gpio_i through two flops; IN reads second stage (2-cycle latency).
REQ-015 Write FSM SHALL have states W_IDLE and W_RESP; aw_ready_o = w_ready_o = 1 only in W_IDLE with aw_valid_i and w_valid_i both high.
REQ-016 SHALL never accept AW without W or W without AW in the same cycle.
REQ-017 On write handshake (cycle N): SHALL update OUT/DIR bytes per w_strb_i at edge ending N; b_valid_o high from N+1; go to W_RESP.
REQ-018 In W_RESP b_valid_o and b_resp_o SHALL stay stable until b_ready_i; return to W_IDLE on that edge; no new AW/W accepted in W_RESP.
REQ-019 Read FSM SHALL have states R_IDLE and R_DATA; ar_ready_o = 1 in R_IDLE only.
REQ-020 On AR handshake (cycle N): SHALL capture read data at cycle N (pre-write value if same-cycle write) and assert r_valid_o from N+1.
REQ-021 In R_DATA r_data_o/r_resp_o SHALL hold stable until r_ready_i; then R_IDLE.
REQ-022 Response codes: in-window mapped = OKAY 2'b00; in-window unmapped offset = SLVERR 2'b10; out-of-window = DECERR 2'b11.
REQ-023 Error or IN-register writes SHALL modify no state; error reads SHALL return r_data_o = 0.
REQ-024 Read and write channels SHALL operate independently and concurrently.
REQ-025 Writes with w_strb_i = 0 SHALL respond OKAY without changing state.

Reset
REQ-026 While rst_i high at a clock edge: OUT=0, DIR=0, synchroniser=0, both FSMs idle.
REQ-027 During/after reset: gpio_o=0, gpio_oe_o=0, b_valid_o=0, r_valid_o=0, aw_ready_o=w_ready_o=ar_ready_o=0 during reset, b_resp_o=r_resp_o=0, r_data_o=0.
REQ-028 Reset mid-transaction SHALL drop pending B/R responses without completing them.

Verification
REQ-029 AW=0x0010_0000 + W=0xA5A5_0F0F strb=4'hF, bready=1 -> gpio_o=0xA5A5_0F0F next cycle, b_resp=00 one cycle after handshake.
REQ-030 Write DIR (offset 0x8) 0x0000_FFFF strb=4'b0001, prior DIR=0 -> gpio_oe_o=0x0000_00FF.
REQ-031 gpio_i=0x1234_5678 held; read offset 0x4 ≥3 cycles later -> r_data=0x1234_5678, r_resp=00.
REQ-032 AR=0x8000_0000 -> r_resp=11, r_data=0; AW=0x0010_000C -> b_resp=10, OUT/DIR unchanged.
REQ-033 AW valid, W valid later, bready low 5 cycles -> no handshake until W arrives; b_valid held stable 5 cycles with fixed resp; ar channel still serviced meanwhile.
REQ-034 Assert rst_i while b_valid_o=1 and r_valid_o=1 -> both 0 after edge; gpio_o=gpio_oe_o=0.
